// File: rtl/muxarb_pkg.sv
// Shared types and constants for the 8:1 selector arbiter (mux_sel_arbiter).
// State encoding, requester count, select width and the default tenure limit.
package muxarb_pkg;

    localparam int NUM_REQ      = 8;
    localparam int SEL_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        onehot = NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick8.sv
// Combinational rotating-priority picker: searches req from ptr+1 upward with wrap,
// so the requester at ptr itself is checked last.
module rr_pick8
    import muxarb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        // i == NUM_REQ wraps the 3-bit offset back to zero, i.e. ptr itself.
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ptr + SEL_W'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter/sequencer in front of the shared 8:1 single-bit selector.
// Optional tenure limit (MAX_HOLD) and timeout pulse are compiled in with MUXARB_TIMEOUT_EN.
module mux_sel_arbiter
    import muxarb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] data,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               y,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("mux_sel_arbiter: MAX_HOLD must be in 2..255");
    end

    arb_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               y_q, y_d;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_idx;
    logic               hold_expired;

`ifdef MUXARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    assign hold_expired = (hold_cnt_q == HOLD_LAST);
    assign timeout      = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // One picker serves both IDLE and RELEASE; ptr_q already holds the last owner there.
    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        y_d     = (state_q == GRANT) ? data[sel_q] : 1'b0;
`ifdef MUXARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE, RELEASE: begin
                state_d = IDLE;
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = onehot(pick_idx);
`ifdef MUXARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
`ifdef MUXARB_TIMEOUT_EN
                hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                if (!req[sel_q] || hold_expired) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                    ptr_d   = sel_q;
`ifdef MUXARB_TIMEOUT_EN
                    // A drop coinciding with expiry is an ordinary release.
                    timeout_d = req[sel_q];
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            y_q     <= y_d;
        end
    end

`ifdef MUXARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
`endif

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = |gnt_q;
    assign y    = y_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed self-checking bench for mux_sel_arbiter; the timeout scenarios run
// when MUXARB_TIMEOUT_EN is defined, the unlimited-tenure scenario otherwise.
module tb_mux_sel_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       busy;
    logic       y;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    mux_sel_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data    (data),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .y       (y),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] oh(input int i);
        logic [7:0] one;
        one = 8'd1;
        return one << i;
    endfunction

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        data  = 8'h00;

        // Reset values
        #12;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_gnt", 32'(gnt), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_no_req_gnt", 32'(gnt), 32'h00);

        // Single requester 2: grant one edge later, y one further edge later
        req  = 8'h04;
        data = 8'h04;
        step();
        check("t1_gnt", 32'(gnt), 32'h04);
        check("t1_sel", 32'(sel), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_y_first_edge", 32'(y), 32'd0);
        step();
        check("t1_y_hi", 32'(y), 32'd1);
        data = 8'hFB;
        step();
        check("t1_y_lo", 32'(y), 32'd0);
        data = 8'h04;
        step();
        check("t1_y_hi2", 32'(y), 32'd1);
        check("t1_gnt_held", 32'(gnt), 32'h04);
        req = 8'h00;
        step();
        check("t1_rel_gnt", 32'(gnt), 32'h00);
        check("t1_rel_busy", 32'(busy), 32'd0);
        check("t1_rel_sel", 32'(sel), 32'd2);
        check("t1_rel_timeout", 32'(timeout), 32'd0);
        step();
        check("t1_idle_y", 32'(y), 32'd0);
        check("t1_idle_gnt", 32'(gnt), 32'h00);

        // Owner 3 drops while 5 and 1 wait: one dead cycle, then 5 (after 3), then 1
        req  = 8'h08;
        data = 8'h20;
        step();
        check("t3_gnt3", 32'(gnt), 32'h08);
        check("t3_sel3", 32'(sel), 32'd3);
        req = 8'h2A;
        step();
        check("t3_gnt3_held", 32'(gnt), 32'h08);
        req = 8'h22;
        step();
        check("t3_dead_gnt", 32'(gnt), 32'h00);
        check("t3_dead_sel", 32'(sel), 32'd3);
        step();
        check("t3_gnt5", 32'(gnt), 32'h20);
        check("t3_sel5", 32'(sel), 32'd5);
        req = 8'h02;
        step();
        check("t3_rel5_gnt", 32'(gnt), 32'h00);
        check("t3_y_data5", 32'(y), 32'd1);
        step();
        check("t3_gnt1", 32'(gnt), 32'h02);
        check("t3_sel1", 32'(sel), 32'd1);
        req = 8'h00;
        step();
        step();
        check("t3_idle_gnt", 32'(gnt), 32'h00);

        // Reset mid-tenure of requester 4; first grant after reset is lowest index
        req  = 8'h10;
        data = 8'hFF;
        step();
        check("t5_gnt4", 32'(gnt), 32'h10);
        step();
        check("t5_y", 32'(y), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'h00);
        check("t5_async_sel", 32'(sel), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_y", 32'(y), 32'd0);
        check("t5_async_timeout", 32'(timeout), 32'd0);
        req = 8'h90;
        step();
        check("t5_in_reset_gnt", 32'(gnt), 32'h00);
        rst_n = 1'b1;
        step();
        check("t5_first_gnt", 32'(gnt), 32'h10);
        check("t5_first_sel", 32'(sel), 32'd4);
        check("t5_first_busy", 32'(busy), 32'd1);
        req = 8'h00;
        step();
        check("t5_rel_gnt", 32'(gnt), 32'h00);
        step();

`ifdef MUXARB_TIMEOUT_EN
        // All requesting, MAX_HOLD=4: last owner was 4, so rotation starts at 5
        req = 8'hFF;
        for (int t = 0; t < 9; t++) begin
            int owner;
            owner = (5 + t) % 8;
            step();
            check("rot_gnt", 32'(gnt), 32'(oh(owner)));
            check("rot_sel", 32'(sel), 32'(owner));
            check("rot_timeout_lo", 32'(timeout), 32'd0);
            for (int c = 0; c < 3; c++) begin
                step();
                check("rot_gnt_held", 32'(gnt), 32'(oh(owner)));
            end
            step();
            check("rot_gap_gnt", 32'(gnt), 32'h00);
            check("rot_gap_busy", 32'(busy), 32'd0);
            check("rot_timeout_pulse", 32'(timeout), 32'd1);
        end
        req = 8'h00;
        step();
        check("rot_idle_gnt", 32'(gnt), 32'h00);
        check("rot_idle_timeout", 32'(timeout), 32'd0);

        // Lone requester 6 keeps being re-granted: 4 on, 1 dead
        req = 8'h40;
        for (int t = 0; t < 3; t++) begin
            step();
            check("solo_gnt", 32'(gnt), 32'h40);
            check("solo_sel", 32'(sel), 32'd6);
            for (int c = 0; c < 3; c++) begin
                step();
                check("solo_gnt_held", 32'(gnt), 32'h40);
            end
            step();
            check("solo_dead_gnt", 32'(gnt), 32'h00);
            check("solo_dead_sel", 32'(sel), 32'd6);
            check("solo_timeout", 32'(timeout), 32'd1);
        end
        req = 8'h00;
        step();
        check("solo_idle_gnt", 32'(gnt), 32'h00);
`else
        // No tenure limit: requester 0 keeps the line for 300 cycles despite req[1]
        req = 8'h03;
        step();
        check("hold_first_gnt", 32'(gnt), 32'h01);
        for (int c = 0; c < 300; c++) begin
            step();
            check("hold_gnt_timeout", 32'({gnt, timeout}), 32'({8'h01, 1'b0}));
        end
        req = 8'h02;
        step();
        check("hold_rel_gnt", 32'(gnt), 32'h00);
        step();
        check("hold_next_gnt", 32'(gnt), 32'h02);
        req = 8'h00;
        step();
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
